// File: rtl/uart_autobaud.sv
// Automatic baud-rate detector: times a 0x55 sync character on rx and derives
// the baud generator divider as round(T / (8*SAMPLE_RATE)) - 1.
module uart_autobaud #(
    parameter int         SAMPLE_RATE = 24,
    parameter int         CNT_W       = 16,
    parameter int         IDLE_CLKS   = 1024,
    parameter logic [7:0] DEFAULT_CFG = 8'd216
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       rx,
    output logic [7:0] cfg_out,
    output logic       cfg_valid,
    output logic       done,
    output logic       error,
    output logic       busy
);
    localparam int                IDLE_W    = $clog2(IDLE_CLKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);
    localparam logic [CNT_W-1:0]  T_MAX     = '1;
    localparam logic [CNT_W:0]    DIVISOR   = (CNT_W+1)'(8 * SAMPLE_RATE);
    localparam logic [CNT_W:0]    ROUNDING  = (CNT_W+1)'(4 * SAMPLE_RATE);
    localparam logic [8:0]        Q_LIMIT   = 9'd257;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_START,
        MEASURE,
        DIVIDE
    } state_e;

    state_e            state_q, state_d;
    logic              rxMeta_q, rxSync_q, rxPrev_q;
    logic [IDLE_W-1:0] idleCnt_q;
    logic [CNT_W-1:0]  tCnt_q;
    logic [2:0]        fallCnt_q;
    logic [CNT_W:0]    rem_q;
    logic [8:0]        quot_q;
    logic [7:0]        cfg_q;
    logic              valid_q, done_q, error_q;

    logic              fallEdge, idleReached, timeout, fourthFall;
    logic              divStep, quotFull, doneSet, errSet;
    logic [CNT_W-1:0]  tNext;

    // Synchronizer flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    assign fallEdge    = rxPrev_q & ~rxSync_q;
    assign idleReached = rxSync_q && (idleCnt_q == IDLE_LAST);
    assign timeout     = (tCnt_q == T_MAX);
    assign fourthFall  = fallEdge && (fallCnt_q == 3'd3);
    assign divStep     = (rem_q >= DIVISOR);
    assign quotFull    = (quot_q == Q_LIMIT);
    assign tNext       = tCnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        doneSet = 1'b0;
        errSet  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (idleReached) state_d = WAIT_START;
                end
                WAIT_START: begin
                    if (fallEdge) state_d = MEASURE;
                end
                MEASURE: begin
                    if (timeout) begin
                        state_d = IDLE;
                        errSet  = 1'b1;
                    end else if (fourthFall) begin
                        state_d = DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (quotFull) begin
                        state_d = IDLE;
                        errSet  = 1'b1;
                    end else if (!divStep) begin
                        state_d = IDLE;
                        if (quot_q == 9'd0) errSet  = 1'b1;
                        else                doneSet = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // The captured span uses the post-increment count so T equals 8 bit periods exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idleCnt_q <= '0;
            tCnt_q    <= '0;
            fallCnt_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cfg_q     <= DEFAULT_CFG;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= doneSet;
            error_q <= errSet;
            if (doneSet) begin
                cfg_q   <= quot_q[7:0] - 8'd1;
                valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    idleCnt_q <= '0;
                end
                WAIT_IDLE: begin
                    idleCnt_q <= rxSync_q ? idleCnt_q + 1'b1 : '0;
                end
                WAIT_START: begin
                    if (fallEdge) begin
                        tCnt_q    <= '0;
                        fallCnt_q <= '0;
                    end
                end
                MEASURE: begin
                    tCnt_q <= tNext;
                    if (fallEdge) fallCnt_q <= fallCnt_q + 1'b1;
                    if (fourthFall && !timeout) begin
                        rem_q  <= {1'b0, tNext} + ROUNDING;
                        quot_q <= '0;
                    end
                end
                DIVIDE: begin
                    if (divStep && !quotFull) begin
                        rem_q  <= rem_q - DIVISOR;
                        quot_q <= quot_q + 1'b1;
                    end
                end
                default: begin
                    idleCnt_q <= '0;
                end
            endcase
        end
    end

    assign cfg_out   = cfg_q;
    assign cfg_valid = valid_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
